vc_demux_flow_ctrl: RTL and testbench

Write-side counterpart of the main-FIFO pop/valid stage. Consumes the one-cycle-delayed valid and data word leaving the main FIFO, steers each word by its class bit into the VC0 or VC1 FIFO push port, tracks the occupancy of both VC FIFOs, and generates the `pause_vc0`/`pause_vc1` back-pressure that gates popping of the main FIFO. Sits between the main FIFO read port and the two VC FIFO write ports.

---
 rtl/vc_demux_flow_ctrl.sv | 114 +++++++++++
 tb/tb_vc_demux_flow_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vc_demux_flow_ctrl.sv
// Steers words leaving the main FIFO into the VC0/VC1 FIFO push ports, tracks
// per-VC occupancy and raises hysteretic pause back-pressure to the main-FIFO pop logic.
module vc_demux_flow_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int PAUSE_HI   = 3,
  parameter int PAUSE_LO   = 1,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop_vc0,
  input  logic                  pop_vc1,
  output logic                  push_vc0,
  output logic                  push_vc1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  pause_vc0,
  output logic                  pause_vc1,
  output logic [CW-1:0]         count_vc0,
  output logic [CW-1:0]         count_vc1,
  output logic                  overflow,
  output logic                  underflow
);

  typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} vc_state_e;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HI_C    = CW'(PAUSE_HI);
  localparam logic [CW-1:0] LO_C    = CW'(PAUSE_LO);

  logic [CW-1:0]         count_q [2];
  logic [CW-1:0]         count_d [2];
  vc_state_e             state_q [2];
  vc_state_e             state_d [2];
  logic [1:0]            push_q, push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [1:0]            push_req, pop_req, pop_acc;
  logic [1:0]            pause_c;

  assign push_req = {valid_in &  data_in[DATA_WIDTH-1],
                     valid_in & ~data_in[DATA_WIDTH-1]};
  assign pop_req  = {pop_vc1, pop_vc0};

  // A full VC still takes a word when the same cycle frees a slot.
  always_comb begin
    data_d      = valid_in ? data_in : data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    pop_acc     = '0;
    push_d      = '0;
    for (int v = 0; v < 2; v++) begin
      pop_acc[v] = pop_req[v] && (count_q[v] != '0);
      push_d[v]  = push_req[v] && ((count_q[v] < DEPTH_C) || pop_req[v]);
      if (push_req[v] && (count_q[v] == DEPTH_C) && !pop_req[v])
        overflow_d = 1'b1;
      if (pop_req[v] && (count_q[v] == '0))
        underflow_d = 1'b1;
      count_d[v] = count_q[v] + CW'(push_d[v]) - CW'(pop_acc[v]);
    end
  end

  always_comb begin
    for (int v = 0; v < 2; v++) begin
      state_d[v] = state_q[v];
      case (state_q[v])
        RUN:     if (count_d[v] >= HI_C) state_d[v] = PAUSE;
        PAUSE:   if (count_d[v] <= LO_C) state_d[v] = RUN;
        default: state_d[v] = RUN;
      endcase
    end
  end

  always_comb begin
    for (int v = 0; v < 2; v++)
      pause_c[v] = (state_q[v] == PAUSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_q      <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int v = 0; v < 2; v++) begin
        count_q[v] <= '0;
        state_q[v] <= RUN;
      end
    end else begin
      push_q      <= push_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      for (int v = 0; v < 2; v++) begin
        count_q[v] <= count_d[v];
        state_q[v] <= state_d[v];
      end
    end
  end

  assign push_vc0  = push_q[0];
  assign push_vc1  = push_q[1];
  assign data_out  = data_q;
  assign pause_vc0 = pause_c[0];
  assign pause_vc1 = pause_c[1];
  assign count_vc0 = count_q[0];
  assign count_vc1 = count_q[1];
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vc_demux_flow_ctrl.sv
// Scoreboard bench for vc_demux_flow_ctrl: a behavioural model queues the expected
// outputs for every driven cycle, which are popped and compared after the next edge.
module tb_vc_demux_flow_ctrl;

  localparam int DW = 6;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          pop_vc0, pop_vc1;
  logic          push_vc0, push_vc1;
  logic [DW-1:0] data_out;
  logic          pause_vc0, pause_vc1;
  logic [CW-1:0] count_vc0, count_vc1;
  logic          overflow, underflow;

  vc_demux_flow_ctrl dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_vc0(push_vc0), .push_vc1(push_vc1), .data_out(data_out),
    .pause_vc0(pause_vc0), .pause_vc1(pause_vc1),
    .count_vc0(count_vc0), .count_vc1(count_vc1),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int push0, push1, data, cnt0, cnt1, pause0, pause1, ovf, udf;
  } exp_t;

  exp_t exp_q[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;

  // Independent reference model state
  int m_cnt[2];
  int m_pause[2];
  int m_data, m_ovf, m_udf;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s (cycle %0d): observed %0d, expected %0d",
                  tag, cycle, observed, expected);
  endtask

  task automatic modelStep(input bit rst, input bit v, input int d,
                           input bit p0, input bit p1, output exp_t e);
    int push_out[2];
    bit pop_v[2];
    pop_v[0] = p0;
    pop_v[1] = p1;
    push_out[0] = 0;
    push_out[1] = 0;
    if (rst) begin
      m_cnt[0] = 0; m_cnt[1] = 0; m_pause[0] = 0; m_pause[1] = 0;
      m_data = 0; m_ovf = 0; m_udf = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int pop_ok, push_ok, nxt;
        bit want;
        want    = v && (((d >> 5) & 1) == k);
        pop_ok  = (pop_v[k] && m_cnt[k] > 0) ? 1 : 0;
        push_ok = 0;
        if (pop_v[k] && m_cnt[k] == 0) m_udf = 1;
        if (want) begin
          if (m_cnt[k] < 4 || pop_v[k]) push_ok = 1;
          else m_ovf = 1;
        end
        nxt = m_cnt[k] + push_ok - pop_ok;
        if (m_pause[k] == 0 && nxt >= 3) m_pause[k] = 1;
        else if (m_pause[k] == 1 && nxt <= 1) m_pause[k] = 0;
        m_cnt[k] = nxt;
        push_out[k] = push_ok;
      end
      if (v) m_data = d;
    end
    e.push0 = push_out[0]; e.push1 = push_out[1]; e.data = m_data;
    e.cnt0 = m_cnt[0]; e.cnt1 = m_cnt[1];
    e.pause0 = m_pause[0]; e.pause1 = m_pause[1];
    e.ovf = m_ovf; e.udf = m_udf;
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input int d,
                               input bit p0, input bit p1);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    valid_in = v;
    data_in  = DW'(d);
    pop_vc0  = p0;
    pop_vc1  = p1;
    modelStep(rst, v, d, p0, p1, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cycle++;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      checkOutput("push_vc0",  int'(push_vc0),  e.push0);
      checkOutput("push_vc1",  int'(push_vc1),  e.push1);
      checkOutput("data_out",  int'(data_out),  e.data);
      checkOutput("count_vc0", int'(count_vc0), e.cnt0);
      checkOutput("count_vc1", int'(count_vc1), e.cnt1);
      checkOutput("pause_vc0", int'(pause_vc0), e.pause0);
      checkOutput("pause_vc1", int'(pause_vc1), e.pause1);
      checkOutput("overflow",  int'(overflow),  e.ovf);
      checkOutput("underflow", int'(underflow), e.udf);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = '0; pop_vc0 = 1'b0; pop_vc1 = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_pause[0] = 0; m_pause[1] = 0;
    m_data = 0; m_ovf = 0; m_udf = 0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 6'h25, 1, 1);

    // Reset mid-stream, then traffic resumes
    applyStimulus(0, 1, 6'h01, 0, 0);
    applyStimulus(0, 1, 6'h02, 0, 0);
    applyStimulus(0, 1, 6'h03, 0, 0);
    applyStimulus(1, 1, 6'h04, 0, 0);
    applyStimulus(0, 1, 6'h06, 0, 0);
    idle(1);

    // Steering by class bit
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 6'b0_00101, 0, 0);
    applyStimulus(0, 1, 6'b1_01010, 0, 0);
    idle(2);

    // VC0 hysteresis
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 6'h08 + i, 0, 0);
    idle(1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    idle(1);

    // VC1 simultaneous push+pop at count 3
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 6'h20 + i, 0, 0);
    applyStimulus(0, 1, 6'h33, 0, 1);
    idle(1);

    // VC0 overflow, then a full push paired with a pop
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 6'h10 + i, 0, 0);
    applyStimulus(0, 1, 6'h1F, 0, 0);
    idle(1);
    applyStimulus(0, 1, 6'h1E, 1, 0);
    idle(1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 6'h07, 0, 0);

    // VC1 underflow alongside a VC0 push
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 6'h09, 0, 1);
    idle(2);

    // Mixed random traffic with occasional resets
    for (int i = 0; i < 200; i++)
      applyStimulus(($urandom_range(0, 29) == 0), $urandom_range(0, 1),
                    int'($urandom_range(0, 63)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
